bcd_display_scan_ctrl: RTL and testbench
========================================

Name: bcd_display_scan_ctrl

Overview:
- Time-multiplexed scan controller that drives the eight-digit 7-segment display of the wall clock / alarm.
- Takes the packed 32-bit BCD word (digit 0 in bits 3:0, digit 7 in bits 31:28), snapshots it once per scan frame and steps through the digits one slot at a time.
- Drives one active-low anode per slot with its decoded segments, including guard (dead) time, blinking of the field being set, and leading-zero suppression.

Parameters:
- PRESCALE, 1000: clk cycles per digit slot (≥ GUARD+1).
- GUARD, 50: cycles at the start of each slot with all anodes off (anti-ghosting).
- BLINK_FRAMES, 64: full scan frames per blink half-period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; 0 = display dark, scan state held at slot 0
- bcd  in  32  packed BCD, 8 nibbles, digit k = bcd[4k+3:4k]
- blink_mask  in  8  bit k=1: digit k blinks
- lz_en  in  1  leading-zero suppression enable
- anode_n  out  8  active-low digit select, at most one bit low
- seg  out  7  active-high segments {g,f,e,d,c,b,a}
- frame_start  out  1  one-cycle pulse at start of slot 0

Behaviour:
- Reset (rst_n low, asynchronous): anode_n=8'hFF, seg=0, frame_start=0, phase=0, slot=0, frame counter=0, blink_phase=0, snapshot registers=0.
- Counters:
  - phase counts 0..PRESCALE-1 each clk while en=1.
  - At phase=PRESCALE-1, phase wraps to 0 and slot increments 0..7; slot wraps 7→0.
  - At the 7→0 slot wrap, the frame counter increments. When it reaches BLINK_FRAMES-1, it clears and blink_phase toggles.
- Snapshot:
  - Taken on the cycle where slot=0 and phase=0: bcd, blink_mask and lz_en are registered.
  - The whole frame displays the snapshot, so no tearing when time updates mid-frame.
  - frame_start=1 on that same cycle only.
  - The first snapshot after reset or after en rises is taken on the first enabled cycle.
- Per-slot FSM (encoded by phase):
  - GUARD state while phase<GUARD: anode_n=8'hFF, seg=0.
  - SHOW state while phase≥GUARD: anode_n has bit slot low (others high) and seg=decode(digit[slot]), unless the digit is blanked.
  - Blanked digit: anode_n=8'hFF, seg=0.
  - Outputs are registered, so they reflect the state one cycle after the counters.
- Blanking rules for digit k:
  - (a) blink_phase=1 and snapshot blink_mask[k]=1.
  - (b) Leading-zero suppression: lz_en=1 and digits 7..k are all zero (0x0). Digit 0 is never blanked by this rule.
- Decode:
  - 0–9 use standard patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, bit0=a).
  - Non-BCD values A–F show dash 7'h40.
- en=0:
  - Synchronously, the next cycle: anode_n=8'hFF, seg=0, phase=0, slot=0.
  - Frame counter and blink_phase are held.
  - On re-enable, scan restarts at slot 0 with a fresh snapshot.
- Simultaneous events: the snapshot and the frame-counter increment/blink toggle occur on the same wrap boundary. The new blink_phase applies to the frame being started.
- Reset asserted mid-slot: outputs go dark immediately (asynchronous), with no completion of the current slot.

Test Plan (PRESCALE=4, GUARD=1, BLINK_FRAMES=2):
- Reset then en=1, bcd=32'h12345678, masks 0 -> frame_start pulse every 32 cycles; slot k anode_n=~(1<<k) for 3 of 4 cycles, 8'hFF in the guard cycle; slot0 seg=7F, slot7 seg=06.
- Change bcd to 32'h00000000 at slot 3 mid-frame -> digits 3–7 of the current frame still show old values; new values appear only after the next frame_start.
- lz_en=1, bcd=32'h00000905 -> digits 7..3 dark (anode_n=FF); digits 2,1,0 show 6F, 3F, 6D; bcd=0 -> only digit 0 shows 3F.
- blink_mask=8'h03 -> digits 0–1 visible for 2 frames, dark for 2 frames, repeating; other digits always lit.
- Digit value 0xB in slot 4 -> seg=40 during its show window.
- Drop en mid-slot 5, raise after 10 cycles -> dark the cycle after the drop; resumes at slot 0 with frame_start; rst_n low mid-show -> anode_n=FF asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/bcd_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_display_scan_ctrl
//
// Time-multiplexed scan controller for an eight-digit 7-segment display.
// The packed BCD word is snapshotted once per scan frame (slot 0, phase 0) so
// a time update in the middle of a frame never tears the display. Each digit
// slot lasts PRESCALE clocks; the first GUARD clocks of a slot keep every
// anode off to avoid ghosting. Digits can blink (BLINK_FRAMES frames on,
// BLINK_FRAMES frames off) and leading zeros can be suppressed.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           scan enable; 0 = display dark, scan held at slot 0
//   bcd[31:0]    packed BCD, digit k = bcd[4k+3:4k]
//   blink_mask   bit k = 1 makes digit k blink
//   lz_en        leading-zero suppression enable
//   anode_n[7:0] active-low digit select, at most one bit low (registered)
//   seg[6:0]     active-high segments {g,f,e,d,c,b,a} (registered)
//   frame_start  one-cycle pulse aligned with the first output cycle of slot 0
// -----------------------------------------------------------------------------
module bcd_display_scan_ctrl #(
   parameter int PRESCALE     = 1000,
   parameter int GUARD        = 50,
   parameter int BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] bcd,
   input  logic [7:0]  blink_mask,
   input  logic        lz_en,
   output logic [7:0]  anode_n,
   output logic [6:0]  seg,
   output logic        frame_start
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PHASE_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   typedef enum logic {
      ST_GUARD = 1'b0,
      ST_SHOW  = 1'b1
   } slot_state_t;

   // Digit value to segment pattern; anything outside 0..9 shows a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'h0:    pattern = 7'h3F;
         4'h1:    pattern = 7'h06;
         4'h2:    pattern = 7'h5B;
         4'h3:    pattern = 7'h4F;
         4'h4:    pattern = 7'h66;
         4'h5:    pattern = 7'h6D;
         4'h6:    pattern = 7'h7D;
         4'h7:    pattern = 7'h07;
         4'h8:    pattern = 7'h7F;
         4'h9:    pattern = 7'h6F;
         default: pattern = 7'h40;
      endcase
      return pattern;
   endfunction

   // Counter and snapshot state
   logic [PW-1:0] phase_r;
   logic [2:0]    slot_r;
   logic [FW-1:0] frame_cnt_r;
   logic          blink_phase_r;
   logic [31:0]   snap_bcd_r;
   logic [7:0]    snap_mask_r;
   logic          snap_lz_r;

   // Output registers
   logic [7:0]    anode_n_r;
   logic [6:0]    seg_r;
   logic          frame_start_r;

   // Next-state values
   logic [PW-1:0] phase_nxt_s;
   logic [2:0]    slot_nxt_s;
   logic [FW-1:0] frame_cnt_nxt_s;
   logic          blink_phase_nxt_s;
   logic [7:0]    anode_n_nxt_s;
   logic [6:0]    seg_nxt_s;

   // Snapshot view used for this cycle's decode
   logic          take_snap_s;
   logic [31:0]   snap_bcd_s;
   logic [7:0]    snap_mask_s;
   logic          snap_lz_s;

   logic [7:0]    lz_blank_s;
   logic [3:0]    digit_s;
   logic          blank_s;
   slot_state_t   state_s;

   // Snapshot strobe; the registered snapshot is bypassed on the strobe cycle
   // so that a zero-length guard still shows the fresh frame data.
   always_comb begin
      take_snap_s = en && (slot_r == 3'd0) && (phase_r == {PW{1'b0}});
      if (take_snap_s) begin
         snap_bcd_s  = bcd;
         snap_mask_s = blink_mask;
         snap_lz_s   = lz_en;
      end else begin
         snap_bcd_s  = snap_bcd_r;
         snap_mask_s = snap_mask_r;
         snap_lz_s   = snap_lz_r;
      end
   end

   // Phase/slot/frame counters; frame counter and blink phase hold while disabled.
   always_comb begin
      phase_nxt_s       = phase_r;
      slot_nxt_s        = slot_r;
      frame_cnt_nxt_s   = frame_cnt_r;
      blink_phase_nxt_s = blink_phase_r;
      if (!en) begin
         phase_nxt_s = {PW{1'b0}};
         slot_nxt_s  = 3'd0;
      end else if (phase_r == PHASE_LAST) begin
         phase_nxt_s = {PW{1'b0}};
         slot_nxt_s  = slot_r + 3'd1;
         if (slot_r == 3'd7) begin
            // The toggle lands on the wrap edge, so the frame about to start
            // is already displayed with the new blink phase.
            if (frame_cnt_r == FRAME_LAST) begin
               frame_cnt_nxt_s   = {FW{1'b0}};
               blink_phase_nxt_s = ~blink_phase_r;
            end else begin
               frame_cnt_nxt_s   = frame_cnt_r + FW'(1);
               blink_phase_nxt_s = blink_phase_r;
            end
         end else begin
            frame_cnt_nxt_s   = frame_cnt_r;
            blink_phase_nxt_s = blink_phase_r;
         end
      end else begin
         phase_nxt_s = phase_r + PW'(1);
         slot_nxt_s  = slot_r;
      end
   end

   // Leading-zero map: digit k is blanked when it and every digit above it are zero.
   always_comb begin : lz_map
      logic run_v;
      run_v      = snap_lz_s;
      lz_blank_s = 8'h00;
      for (int k = 7; k >= 1; k--) begin
         run_v         = run_v & (snap_bcd_s[4*k +: 4] == 4'h0);
         lz_blank_s[k] = run_v;
      end
      lz_blank_s[0] = 1'b0;
   end

   // Per-slot state, current digit and its blanking decision.
   always_comb begin
      if (phase_r < GUARD_END) begin
         state_s = ST_GUARD;
      end else begin
         state_s = ST_SHOW;
      end
      digit_s = snap_bcd_s[{slot_r, 2'b00} +: 4];
      blank_s = (blink_phase_r & snap_mask_s[slot_r]) | lz_blank_s[slot_r];
   end

   // Output next-state: dark when disabled, in guard, or when the digit is blanked.
   always_comb begin
      anode_n_nxt_s = 8'hFF;
      seg_nxt_s     = 7'h00;
      if (!en) begin
         anode_n_nxt_s = 8'hFF;
         seg_nxt_s     = 7'h00;
      end else begin
         case (state_s)
            ST_GUARD: begin
               anode_n_nxt_s = 8'hFF;
               seg_nxt_s     = 7'h00;
            end
            ST_SHOW: begin
               if (blank_s) begin
                  anode_n_nxt_s = 8'hFF;
                  seg_nxt_s     = 7'h00;
               end else begin
                  anode_n_nxt_s = ~(8'h01 << slot_r);
                  seg_nxt_s     = seg_decode(digit_s);
               end
            end
            default: begin
               anode_n_nxt_s = 8'hFF;
               seg_nxt_s     = 7'h00;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset to a dark display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_r       <= {PW{1'b0}};
         slot_r        <= 3'd0;
         frame_cnt_r   <= {FW{1'b0}};
         blink_phase_r <= 1'b0;
         snap_bcd_r    <= 32'h0000_0000;
         snap_mask_r   <= 8'h00;
         snap_lz_r     <= 1'b0;
         anode_n_r     <= 8'hFF;
         seg_r         <= 7'h00;
         frame_start_r <= 1'b0;
      end else begin
         phase_r       <= phase_nxt_s;
         slot_r        <= slot_nxt_s;
         frame_cnt_r   <= frame_cnt_nxt_s;
         blink_phase_r <= blink_phase_nxt_s;
         snap_bcd_r    <= snap_bcd_s;
         snap_mask_r   <= snap_mask_s;
         snap_lz_r     <= snap_lz_s;
         anode_n_r     <= anode_n_nxt_s;
         seg_r         <= seg_nxt_s;
         frame_start_r <= take_snap_s;
      end
   end

   assign anode_n     = anode_n_r;
   assign seg         = seg_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for bcd_display_scan_ctrl (PRESCALE=4, GUARD=1,
// BLINK_FRAMES=2). A reference model tracks the number of enabled cycles since
// the scan (re)started and the number of completed frames, and derives slot,
// phase, blink state and blanking from those with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_bcd_display_scan_ctrl;

   localparam int P  = 4;
   localparam int G  = 1;
   localparam int BF = 2;
   localparam int FRAME = 8 * P;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [31:0] bcd;
   logic [7:0]  blink_mask;
   logic        lz_en;
   logic [7:0]  anode_n;
   logic [6:0]  seg;
   logic        frame_start;

   always #5 clk = ~clk;

   bcd_display_scan_ctrl #(.PRESCALE(P), .GUARD(G), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .bcd(bcd), .blink_mask(blink_mask),
      .lz_en(lz_en), .anode_n(anode_n), .seg(seg), .frame_start(frame_start)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int          en_cycles = 0;
   int          frames_done = 0;
   int          last_pos = -1;
   logic [31:0] m_bcd = 32'h0;
   logic [7:0]  m_mask = 8'h0;
   logic        m_lz = 1'b0;
   logic [7:0]  e_anode;
   logic [6:0]  e_seg;
   logic        e_fs;

   typedef struct {
      logic [31:0]     bcd;
      logic            lz;
      logic [7:0]      vis;
      logic [7:0][6:0] segs;
   } vec_t;
   vec_t tv[7];

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      logic [6:0] lut[10];
      lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      if (d > 4'd9) return 7'h40;
      return lut[d];
   endfunction

   function automatic logic ref_blank(input int k);
      logic blink_on, lz_dark;
      blink_on = (((frames_done / BF) % 2) == 1) && m_mask[k];
      lz_dark  = (k != 0) && m_lz && ((m_bcd >> (4 * k)) == 32'h0);
      return blink_on || lz_dark;
   endfunction

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // one clock: advance the model on the edge, then compare all outputs
   task automatic tick();
      int pos, slot, ph;
      @(posedge clk);
      if (!rst_n) begin
         e_anode = 8'hFF; e_seg = 7'h00; e_fs = 1'b0;
         en_cycles = 0; frames_done = 0; last_pos = -1;
         m_bcd = 32'h0; m_mask = 8'h0; m_lz = 1'b0;
      end else if (!en) begin
         e_anode = 8'hFF; e_seg = 7'h00; e_fs = 1'b0;
         en_cycles = 0; last_pos = -1;
      end else begin
         pos = en_cycles % FRAME;
         if (pos == 0) begin
            m_bcd = bcd; m_mask = blink_mask; m_lz = lz_en;
         end
         slot = pos / P;
         ph   = pos % P;
         e_fs = (pos == 0);
         if (ph < G || ref_blank(slot)) begin
            e_anode = 8'hFF; e_seg = 7'h00;
         end else begin
            e_anode = ~(8'h01 << slot);
            e_seg   = ref_seg(m_bcd[4*slot +: 4]);
         end
         en_cycles++;
         if (pos == FRAME - 1) frames_done++;
         last_pos = pos;
      end
      #1;
      n_cmp++;
      if (anode_n !== e_anode || seg !== e_seg || frame_start !== e_fs) begin
         n_bad++;
         $display("FAIL model: anode_n=%h seg=%h fs=%b, expected anode_n=%h seg=%h fs=%b (t=%0t)",
                  anode_n, seg, frame_start, e_anode, e_seg, e_fs, $time);
      end
   endtask

   // tick until the model reaches counter position 'target' (bounded)
   task automatic run_to(input int target, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 4 * FRAME && !hit; i++) begin
         tick();
         if (last_pos == target) hit = 1'b1;
      end
      if (!hit) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: position %0d not reached within budget", name, target);
      end
   endtask

   // restart scan cleanly with the given data
   task automatic restart(input logic [31:0] b, input logic [7:0] m, input logic l);
      en = 1'b0;
      tick();
      bcd = b; blink_mask = m; lz_en = l; en = 1'b1;
   endtask

   initial begin
      int fs_count;
      rst_n = 1'b0; en = 1'b0; bcd = 32'h0; blink_mask = 8'h0; lz_en = 1'b0;

      tv[0] = '{32'h12345678, 1'b0, 8'hFF, {7'h06,7'h5B,7'h4F,7'h66,7'h6D,7'h7D,7'h07,7'h7F}};
      tv[1] = '{32'h00000905, 1'b1, 8'h07, {7'h00,7'h00,7'h00,7'h00,7'h00,7'h6F,7'h3F,7'h6D}};
      tv[2] = '{32'h00000000, 1'b1, 8'h01, {7'h00,7'h00,7'h00,7'h00,7'h00,7'h00,7'h00,7'h3F}};
      tv[3] = '{32'h000B0000, 1'b0, 8'hFF, {7'h3F,7'h3F,7'h3F,7'h40,7'h3F,7'h3F,7'h3F,7'h3F}};
      tv[4] = '{32'hFEDCBA98, 1'b0, 8'hFF, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h6F,7'h7F}};
      tv[5] = '{32'h00100000, 1'b1, 8'h3F, {7'h00,7'h00,7'h06,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F}};
      tv[6] = '{32'h90000000, 1'b1, 8'hFF, {7'h6F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F}};

      // reset state
      tick(); tick();
      check_val("reset_anode", {24'h0, anode_n}, 32'hFF);
      check_val("reset_seg", {25'h0, seg}, 32'h0);
      rst_n = 1'b1;

      // basic scan, frame_start every 32 cycles
      en = 1'b1; bcd = 32'h12345678;
      fs_count = 0;
      for (int c = 0; c < 2 * FRAME; c++) begin
         tick();
         if (frame_start) fs_count++;
         if (c == 0)  check_val("fs_first", {31'h0, frame_start}, 32'h1);
         if (c == 32) check_val("fs_period", {31'h0, frame_start}, 32'h1);
         if (c == 0)  check_val("guard_slot0", {24'h0, anode_n}, 32'hFF);
         if (c == 2)  check_val("slot0_seg", {25'h0, seg}, 32'h7F);
         if (c == 30) check_val("slot7_seg", {25'h0, seg}, 32'h06);
         if (c == 30) check_val("slot7_anode", {24'h0, anode_n}, 32'h7F);
      end
      check_val("fs_count", fs_count, 2);

      // mid-frame update must not tear the current frame
      run_to(12, "midframe_slot3");
      bcd = 32'h00000000;
      run_to(14, "midframe_d3");
      check_val("old_digit3", {25'h0, seg}, 32'h6D);
      run_to(30, "midframe_d7");
      check_val("old_digit7", {25'h0, seg}, 32'h06);
      run_to(30, "newframe_d7");
      check_val("new_digit7", {25'h0, seg}, 32'h3F);

      // table-driven decode / leading-zero vectors
      for (int v = 0; v < 7; v++) begin
         restart(tv[v].bcd, 8'h00, tv[v].lz);
         for (int c = 0; c < FRAME; c++) begin
            tick();
            if (last_pos % P == 2) begin
               check_val($sformatf("vec%0d_anode_s%0d", v, last_pos / P), {24'h0, anode_n},
                         tv[v].vis[last_pos / P] ? {24'h0, ~(8'h01 << (last_pos / P))} : 32'hFF);
               check_val($sformatf("vec%0d_seg_s%0d", v, last_pos / P), {25'h0, seg},
                         tv[v].vis[last_pos / P] ? {25'h0, tv[v].segs[last_pos / P]} : 32'h0);
            end
         end
      end

      // blink: from reset, digits 0-1 lit 2 frames, dark 2 frames
      rst_n = 1'b0; en = 1'b0;
      tick();
      rst_n = 1'b1;
      bcd = 32'h12345678; blink_mask = 8'h03; lz_en = 1'b0; en = 1'b1;
      for (int f = 0; f < 8; f++) begin
         for (int c = 0; c < FRAME; c++) begin
            tick();
            if (c == 2)
               check_val($sformatf("blink_d0_f%0d", f), {24'h0, anode_n}, ((f % 4) < 2) ? 32'hFE : 32'hFF);
            if (c == 10)
               check_val($sformatf("steady_d2_f%0d", f), {24'h0, anode_n}, 32'hFB);
         end
      end

      // enable drop mid slot 5, re-enable after 10 cycles
      restart(32'h12345678, 8'h00, 1'b0);
      run_to(21, "en_slot5");
      en = 1'b0;
      tick();
      check_val("en_drop_dark", {24'h0, anode_n}, 32'hFF);
      for (int i = 0; i < 9; i++) tick();
      en = 1'b1;
      tick();
      check_val("en_resume_fs", {31'h0, frame_start}, 32'h1);
      tick(); tick();
      check_val("en_resume_slot0", {24'h0, anode_n}, 32'hFE);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         tick();
         if ($urandom_range(0, 19) == 0) begin
            for (int k = 0; k < 8; k++)
               bcd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 39) == 0) blink_mask = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 39) == 0) lz_en = 1'($urandom_range(0, 1));
         if (en && $urandom_range(0, 59) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
      end

      // asynchronous reset in the middle of a show window
      restart(32'h12345678, 8'h00, 1'b0);
      run_to(10, "async_slot2");
      check_val("pre_reset_lit", {24'h0, anode_n}, 32'hFB);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_reset_anode", {24'h0, anode_n}, 32'hFF);
      check_val("async_reset_seg", {25'h0, seg}, 32'h0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < FRAME; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
